door_direction_sensor: RTL and testbench
========================================

Name: door_direction_sensor

Overview:
- Upstream stage of the auditorium occupancy counter.
- Converts two raw IR beam-break sensors at the auditorium door into single-cycle entry/exit pulses. Sensor a_raw is the outer beam; b_raw is the inner beam.
- The pulses drive the counter's inc_enable/dec_enable directly: one pulse means exactly one count step.
- Contains per-sensor synchronisation, debounce and a direction-decoding FSM with jam timeout.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced sensor level changes (>=1)
TIMEOUT_CYCLES, 64, cycles without any debounced input change, in a non-idle state, before the JAM state is declared (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
a_raw  input  1  outer beam, 1 = blocked, asynchronous
b_raw  input  1  inner beam, 1 = blocked, asynchronous
err_clr  input  1  clears sticky jam_err
inc_enable  output  1  one-cycle pulse per completed entry
dec_enable  output  1  one-cycle pulse per completed exit
busy  output  1  high whenever the FSM is not in IDLE
jam_err  output  1  sticky; set on entry to JAM

Behaviour:
- Reset:
  - sync flops, debounced levels, debounce counters and timeout counter go to 0; FSM goes to IDLE.
  - inc_enable, dec_enable, busy and jam_err are 0.
- Synchroniser: 2-flop chain per sensor.
- Debounce:
  - Per-sensor counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while the synchronised level differs from the debounced level; it clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- FSM input is the debounced pair {A,B}.
- States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, JAM.
- IDLE:
  - {1,0} -> EN_A; {0,1} -> EX_B.
  - {1,1} stays in IDLE (ambiguous, ignored); {0,0} stays in IDLE.
- Entry path:
  - EN_A: {1,1} -> EN_AB; {0,1} -> EN_B; {0,0} -> IDLE, no pulse (backed out).
  - EN_AB: {0,1} -> EN_B; {1,0} -> EN_A; {0,0} -> IDLE, no pulse.
  - EN_B: {0,0} -> IDLE and inc_enable pulse; {1,1} -> EN_AB; {1,0} -> EN_A.
- Exit path: mirror of the entry path with A and B swapped (EX_B/EX_BA/EX_A); EX_A with {0,0} -> IDLE and dec_enable pulse.
- Any state not listed for a given input holds.
- Pulses:
  - Registered; high for exactly one cycle after the edge on which the completing transition is taken.
  - inc_enable and dec_enable are never high together.
  - Both are 0 in any cycle where reset is high.
- Timeout:
  - Counter is cleared on any debounced input change and in IDLE/JAM; it saturates.
  - On reaching TIMEOUT_CYCLES in any other state -> JAM, set jam_err, no pulse.
- JAM: waits for {0,0} held for one cycle -> IDLE, no pulse.
- jam_err:
  - Stays set until err_clr.
  - When err_clr and a new jam occur in the same cycle, set wins.
- busy = (state != IDLE), registered alongside the state.
- Reset mid-sequence: the sequence is abandoned with no pulse; the FSM restarts in IDLE on the next cycle.

Optional Feature:
- Macro DOOR_STATS_EN.
- When defined:
  - Adds outputs entry_total[7:0] and exit_total[7:0].
  - Each counter increments on its own pulse and saturates at 255.
  - Both clear on reset and on err_clr.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Clean entry, A=1 / AB=11 / B=1 / 00, each step held 10 cycles -> exactly one inc_enable pulse of 1 cycle, dec_enable stays 0, busy returns to 0.
- Clean exit, mirror sequence -> exactly one dec_enable pulse.
- Backout, A=1 then 11 then A=1 then 00 -> no pulses, FSM returns to IDLE.
- 3-cycle glitch on a_raw with DEBOUNCE_CYCLES=4 -> busy stays 0 and no pulse; a 6-cycle pulse does set busy.
- Jam, A held at 1 for 100 cycles with TIMEOUT_CYCLES=64 -> jam_err=1, no pulse. Releasing to 00 returns to IDLE. err_clr clears jam_err on the next edge.
- Five back-to-back entries, then reset asserted mid-way through a sixth -> 5 inc_enable pulses, no sixth. With DOOR_STATS_EN, entry_total reads 5 before reset and 0 after.

Source files
------------

// File: rtl/door_direction_sensor.sv
// Door direction sensor: synchronises and debounces two IR beams and decodes entry/exit pulses.
// Optional DOOR_STATS_EN adds saturating entry_total/exit_total counters.
module door_direction_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  input  logic       err_clr,
  output logic       inc_enable,
  output logic       dec_enable,
  output logic       busy,
  output logic       jam_err
`ifdef DOOR_STATS_EN
  ,
  output logic [7:0] entry_total,
  output logic [7:0] exit_total
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_EN_A, S_EN_AB, S_EN_B, S_EX_B, S_EX_BA, S_EX_A, S_JAM
  } state_t;

  // Bit 1 carries the outer beam (A), bit 0 the inner beam (B).
  logic [1:0]      w_raw;
  logic [1:0]      r_sync_p0;
  logic [1:0]      r_sync_p1;
  logic [1:0]      r_db;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_flip;
  logic            w_db_chg;
  logic [TO_W-1:0] r_to;
  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_inc_nxt;
  logic            w_dec_nxt;
  logic            w_jam_set;
  logic            r_inc;
  logic            r_dec;
  logic            r_busy;
  logic            r_jam;

  assign w_raw = {a_raw, b_raw};

  // Synchroniser and debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_db      <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (w_flip[i]) begin
          r_db[i]     <= r_sync_p1[i];
          r_db_cnt[i] <= '0;
        end else if (r_sync_p1[i] != r_db[i]) begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 2; i++)
      w_flip[i] = (r_sync_p1[i] != r_db[i]) && (r_db_cnt[i] == DB_LAST);
  end

  assign w_db_chg = |w_flip;

  // Jam timer only runs while a crossing is in progress and inputs are static
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to <= '0;
    end else if (w_db_chg || r_state == S_IDLE || r_state == S_JAM) begin
      r_to <= '0;
    end else if (r_to != TO_MAX) begin
      r_to <= r_to + TO_W'(1);
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_jam   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      if (w_jam_set)    r_jam <= 1'b1;
      else if (err_clr) r_jam <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state != S_IDLE && r_state != S_JAM && r_to == TO_MAX) begin
      w_state_nxt = S_JAM;
    end else begin
      case (r_state)
        S_IDLE:  if (r_db == 2'b10) w_state_nxt = S_EN_A;
                 else if (r_db == 2'b01) w_state_nxt = S_EX_B;
        S_EN_A:  if (r_db == 2'b11) w_state_nxt = S_EN_AB;
                 else if (r_db == 2'b01) w_state_nxt = S_EN_B;
                 else if (r_db == 2'b00) w_state_nxt = S_IDLE;
        S_EN_AB: if (r_db == 2'b01) w_state_nxt = S_EN_B;
                 else if (r_db == 2'b10) w_state_nxt = S_EN_A;
                 else if (r_db == 2'b00) w_state_nxt = S_IDLE;
        S_EN_B:  if (r_db == 2'b00) w_state_nxt = S_IDLE;
                 else if (r_db == 2'b11) w_state_nxt = S_EN_AB;
                 else if (r_db == 2'b10) w_state_nxt = S_EN_A;
        S_EX_B:  if (r_db == 2'b11) w_state_nxt = S_EX_BA;
                 else if (r_db == 2'b10) w_state_nxt = S_EX_A;
                 else if (r_db == 2'b00) w_state_nxt = S_IDLE;
        S_EX_BA: if (r_db == 2'b10) w_state_nxt = S_EX_A;
                 else if (r_db == 2'b01) w_state_nxt = S_EX_B;
                 else if (r_db == 2'b00) w_state_nxt = S_IDLE;
        S_EX_A:  if (r_db == 2'b00) w_state_nxt = S_IDLE;
                 else if (r_db == 2'b11) w_state_nxt = S_EX_BA;
                 else if (r_db == 2'b01) w_state_nxt = S_EX_B;
        S_JAM:   if (r_db == 2'b00) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_inc_nxt = (r_state == S_EN_B) && (w_state_nxt == S_IDLE);
    w_dec_nxt = (r_state == S_EX_A) && (w_state_nxt == S_IDLE);
    w_jam_set = (w_state_nxt == S_JAM) && (r_state != S_JAM);
  end

  // Gated so a pulse can never leak into a cycle where reset is asserted
  assign inc_enable = r_inc & ~reset;
  assign dec_enable = r_dec & ~reset;
  assign busy       = r_busy;
  assign jam_err    = r_jam;

`ifdef DOOR_STATS_EN
  logic [7:0] r_entry_total;
  logic [7:0] r_exit_total;

  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      r_entry_total <= '0;
      r_exit_total  <= '0;
    end else begin
      if (r_inc && r_entry_total != 8'hFF) r_entry_total <= r_entry_total + 8'd1;
      if (r_dec && r_exit_total != 8'hFF)  r_exit_total  <= r_exit_total + 8'd1;
    end
  end

  assign entry_total = r_entry_total;
  assign exit_total  = r_exit_total;
`endif

endmodule

// File: tb/tb_door_direction_sensor.sv
// Directed bench for door_direction_sensor: entry/exit decode, backout, glitch, jam and reset abort.
module tb_door_direction_sensor;

  logic clk = 1'b0;
  logic reset;
  logic a_raw;
  logic b_raw;
  logic err_clr;
  logic inc_enable;
  logic dec_enable;
  logic busy;
  logic jam_err;
`ifdef DOOR_STATS_EN
  logic [7:0] entry_total;
  logic [7:0] exit_total;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_inc  = 0;
  int n_dec  = 0;
  int n_wide = 0;
  int n_both = 0;
  int n_rst_pulse = 0;
  logic busy_seen = 1'b0;
  logic prev_inc  = 1'b0;
  logic prev_dec  = 1'b0;
  int base_inc;
  int base_dec;

  door_direction_sensor #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_raw      (a_raw),
    .b_raw      (b_raw),
    .err_clr    (err_clr),
    .inc_enable (inc_enable),
    .dec_enable (dec_enable),
    .busy       (busy),
    .jam_err    (jam_err)
`ifdef DOOR_STATS_EN
    ,
    .entry_total(entry_total),
    .exit_total (exit_total)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_enable) n_inc++;
    if (dec_enable) n_dec++;
    if (inc_enable && prev_inc) n_wide++;
    if (dec_enable && prev_dec) n_wide++;
    if (inc_enable && dec_enable) n_both++;
    if (reset && (inc_enable || dec_enable)) n_rst_pulse++;
    if (busy) busy_seen = 1'b1;
    prev_inc = inc_enable;
    prev_dec = dec_enable;
  end

  task automatic hold(input logic a, input logic b, input int n);
    a_raw = a;
    b_raw = b;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic entry();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  initial begin
    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0; err_clr = 1'b0;
    hold(1'b0, 1'b0, 3);
    chk("reset_inc", int'(inc_enable), 0);
    chk("reset_dec", int'(dec_enable), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_jam", int'(jam_err), 0);
    reset = 1'b0;
    hold(1'b0, 1'b0, 5);

    // Clean entry
    base_inc = n_inc; base_dec = n_dec;
    hold(1'b1, 1'b0, 10);
    chk("entry_busy_mid", int'(busy), 1);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    chk("entry_inc", n_inc - base_inc, 1);
    chk("entry_dec", n_dec - base_dec, 0);
    chk("entry_busy_end", int'(busy), 0);

    // Clean exit
    base_inc = n_inc; base_dec = n_dec;
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    chk("exit_dec", n_dec - base_dec, 1);
    chk("exit_inc", n_inc - base_inc, 0);
    chk("exit_busy_end", int'(busy), 0);

    // Backout
    base_inc = n_inc; base_dec = n_dec;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    chk("backout_pulses", (n_inc - base_inc) + (n_dec - base_dec), 0);
    chk("backout_busy", int'(busy), 0);

    // Short glitch is filtered, longer pulse is not
    base_inc = n_inc; base_dec = n_dec;
    busy_seen = 1'b0;
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 15);
    chk("glitch3_busy_seen", int'(busy_seen), 0);
    busy_seen = 1'b0;
    hold(1'b1, 1'b0, 6);
    hold(1'b0, 1'b0, 20);
    chk("pulse6_busy_seen", int'(busy_seen), 1);
    chk("pulse6_busy_end", int'(busy), 0);
    chk("glitch_pulses", (n_inc - base_inc) + (n_dec - base_dec), 0);

    // Jam timeout, release, then error clear
    base_inc = n_inc; base_dec = n_dec;
    hold(1'b1, 1'b0, 100);
    chk("jam_err_set", int'(jam_err), 1);
    chk("jam_busy", int'(busy), 1);
    hold(1'b0, 1'b0, 12);
    chk("jam_release_busy", int'(busy), 0);
    chk("jam_err_sticky", int'(jam_err), 1);
    chk("jam_pulses", (n_inc - base_inc) + (n_dec - base_dec), 0);
    err_clr = 1'b1;
    hold(1'b0, 1'b0, 1);
    err_clr = 1'b0;
    chk("jam_err_cleared", int'(jam_err), 0);

    // Five entries, then reset during a sixth
    base_inc = n_inc; base_dec = n_dec;
    for (int k = 0; k < 5; k++) entry();
    chk("five_inc", n_inc - base_inc, 5);
`ifdef DOOR_STATS_EN
    chk("entry_total_5", int'(entry_total), 5);
    chk("exit_total_0", int'(exit_total), 0);
`endif
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    reset = 1'b1;
    hold(1'b0, 1'b0, 3);
    chk("reset_mid_busy", int'(busy), 0);
    reset = 1'b0;
    hold(1'b0, 1'b0, 20);
    chk("sixth_no_inc", n_inc - base_inc, 5);
    chk("sixth_busy", int'(busy), 0);
`ifdef DOOR_STATS_EN
    chk("entry_total_rst", int'(entry_total), 0);
`endif

    chk("pulse_width_one", n_wide, 0);
    chk("never_both", n_both, 0);
    chk("no_pulse_in_reset", n_rst_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
